// File: rtl/vga_pkg.sv
// Shared types and mode table for the VGA receive monitor.
package vga_pkg;

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] HCNT_MAX = 11'd2047;

    typedef enum logic [1:0] {
        RES_640     = 2'b00,
        RES_800     = 2'b01,
        RES_1024    = 2'b10,
        RES_UNKNOWN = 2'b11
    } res_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CW-1:0] htot;
        logic [CW-1:0] hs;
        logic [CW-1:0] hbp;
        logic [CW-1:0] hact;
        logic [CW-1:0] vtot;
        logic [CW-1:0] vs;
        logic [CW-1:0] vbp;
        logic [CW-1:0] vact;
    } mode_t;

    localparam mode_t MODE_640 = '{htot: 11'd800, hs: 11'd96, hbp: 11'd48, hact: 11'd640,
                                   vtot: 11'd525, vs: 11'd2, vbp: 11'd33, vact: 11'd480};
    localparam mode_t MODE_800 = '{htot: 11'd1056, hs: 11'd128, hbp: 11'd88, hact: 11'd800,
                                   vtot: 11'd628, vs: 11'd4, vbp: 11'd23, vact: 11'd600};
    localparam mode_t MODE_1024 = '{htot: 11'd1344, hs: 11'd136, hbp: 11'd160, hact: 11'd1024,
                                    vtot: 11'd806, vs: 11'd6, vbp: 11'd29, vact: 11'd768};

    // Timing parameters for a detected mode; unknown falls back to 640x480 but is never active.
    function automatic mode_t mode_of(input logic [1:0] code);
        case (code)
            RES_800:  return MODE_800;
            RES_1024: return MODE_1024;
            default:  return MODE_640;
        endcase
    endfunction

    function automatic logic [1:0] match_mode(input logic [CW-1:0] h, input logic [CW-1:0] v);
        if (h == MODE_640.htot && v == MODE_640.vtot)   return RES_640;
        if (h == MODE_800.htot && v == MODE_800.vtot)   return RES_800;
        if (h == MODE_1024.htot && v == MODE_1024.vtot) return RES_1024;
        return RES_UNKNOWN;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Polarity-normalised leading-edge detector for one sync line, advancing on pix_en only.
module vga_sync_edge #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync,
    output logic lead_c
);

    logic level_c;
    logic prev;

    assign level_c = (sync == SYNC_POL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (pix_en) begin
            prev <= level_c;
        end
    end

    assign lead_c = pix_en && level_c && !prev;

endmodule

// File: rtl/vga_rx_monitor.sv
// Measures incoming VGA timing, locks onto a known mode and captures active pixels and a frame checksum.
module vga_rx_monitor
    import vga_pkg::*;
#(
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned SUM_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [3:0]       i_r,
    input  logic [3:0]       i_g,
    input  logic [3:0]       i_b,
    input  logic             h_sync,
    input  logic             v_sync,
    output logic             locked,
    output logic [1:0]       res_code,
    output logic             pix_valid,
    output logic [11:0]      pix_rgb,
    output logic [10:0]      x,
    output logic [10:0]      y,
    output logic [10:0]      h_total,
    output logic [10:0]      v_total,
    output logic             frame_done,
    output logic [SUM_W-1:0] frame_sum
);

    logic             hs_lead_c;
    logic             vs_lead_c;
    logic [CW-1:0]    hcnt;
    logic [CW-1:0]    vcnt;
    logic [CW-1:0]    cur_h_c;
    logic [CW-1:0]    cur_v_c;
    logic [CW-1:0]    h_meas_c;
    logic [CW-1:0]    v_meas_c;
    logic [CW-1:0]    h_now_c;
    logic [CW-1:0]    h_start_c;
    logic [CW-1:0]    h_stop_c;
    logic [CW-1:0]    v_start_c;
    logic [CW-1:0]    v_stop_c;
    logic             sat_c;
    logic             active_c;
    logic             valid_c;
    logic [1:0]       match_c;
    mode_t            mode_c;
    state_t           state;
    state_t           state_next;
    logic [1:0]       err_cnt;
    logic [1:0]       err_next;
    logic [1:0]       res_next;
    logic             frame_end_c;
    logic             lost_c;
    logic [SUM_W-1:0] run_sum;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .sync   (h_sync),
        .lead_c (hs_lead_c)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .sync   (v_sync),
        .lead_c (vs_lead_c)
    );

    // Position of the current sample: the value the counters take after this pix_en.
    always_comb begin
        h_meas_c  = hcnt + 11'd1;
        v_meas_c  = vcnt + 11'd1;
        h_now_c   = hs_lead_c ? h_meas_c : h_total;
        cur_h_c   = hs_lead_c ? '0 : ((hcnt == HCNT_MAX) ? hcnt : h_meas_c);
        cur_v_c   = vs_lead_c ? '0 : (hs_lead_c ? v_meas_c : vcnt);
        sat_c     = pix_en && !hs_lead_c && (hcnt == HCNT_MAX);
        mode_c    = mode_of(res_code);
        match_c   = match_mode(h_now_c, v_meas_c);
        h_start_c = mode_c.hs + mode_c.hbp;
        h_stop_c  = h_start_c + mode_c.hact;
        v_start_c = mode_c.vs + mode_c.vbp;
        v_stop_c  = v_start_c + mode_c.vact;
        active_c  = (state == ST_LOCKED)
                 && (cur_h_c >= h_start_c) && (cur_h_c < h_stop_c)
                 && (cur_v_c >= v_start_c) && (cur_v_c < v_stop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        res_next    = res_code;
        err_next    = err_cnt;
        frame_end_c = 1'b0;
        lost_c      = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_lead_c) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (vs_lead_c) begin
                    res_next   = match_c;
                    state_next = (match_c == RES_UNKNOWN) ? ST_SEARCH : ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A single bad line is tolerated; a second one in a row drops lock.
                if (hs_lead_c) begin
                    if (h_meas_c != mode_c.htot) begin
                        err_next = err_cnt + 2'd1;
                        if (err_cnt != 2'd0) begin
                            lost_c = 1'b1;
                        end
                    end else begin
                        err_next = 2'd0;
                    end
                end
                if (vs_lead_c && (v_meas_c != mode_c.vtot)) begin
                    lost_c = 1'b1;
                end
                if (sat_c) begin
                    lost_c = 1'b1;
                end
                if (lost_c) begin
                    state_next = ST_SEARCH;
                    res_next   = RES_UNKNOWN;
                    err_next   = 2'd0;
                end else if (vs_lead_c) begin
                    frame_end_c = 1'b1;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                res_next   = RES_UNKNOWN;
                err_next   = 2'd0;
            end
        endcase
    end

    assign valid_c = pix_en && active_c && (state_next == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt       <= '0;
            vcnt       <= '0;
            err_cnt    <= 2'd0;
            run_sum    <= '0;
            locked     <= 1'b0;
            res_code   <= RES_UNKNOWN;
            pix_valid  <= 1'b0;
            pix_rgb    <= '0;
            x          <= '0;
            y          <= '0;
            h_total    <= '0;
            v_total    <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
        end else begin
            locked     <= (state_next == ST_LOCKED);
            res_code   <= res_next;
            err_cnt    <= err_next;
            frame_done <= frame_end_c;
            pix_valid  <= valid_c;
            if (pix_en) begin
                hcnt <= cur_h_c;
                vcnt <= cur_v_c;
            end
            if (hs_lead_c) begin
                h_total <= h_meas_c;
            end
            if (vs_lead_c) begin
                v_total <= v_meas_c;
            end
            if (valid_c) begin
                pix_rgb <= {i_r, i_g, i_b};
                x       <= cur_h_c - h_start_c;
                y       <= cur_v_c - v_start_c;
            end
            // Sum only accumulates inside a locked frame; any exit discards it.
            if (frame_end_c) begin
                frame_sum <= run_sum;
                run_sum   <= '0;
            end else if (state_next != ST_LOCKED) begin
                run_sum <= '0;
            end else if (valid_c) begin
                run_sum <= run_sum + SUM_W'({i_r, i_g, i_b});
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor: lock, frame capture, line errors, reset and saturation.
module tb_vga_rx_monitor;

    localparam logic SA = 1'b0;
    localparam logic SD = 1'b1;
    localparam int   EXP_SUM = (307200 * 15) % 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [3:0]  i_r;
    logic [3:0]  i_g;
    logic [3:0]  i_b;
    logic        h_sync;
    logic        v_sync;
    logic        locked;
    logic [1:0]  res_code;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        frame_done;
    logic [15:0] frame_sum;

    int checks = 0;
    int errors = 0;
    int valid_cnt;
    int done_cnt;
    int consec_cnt;
    bit first_seen;
    bit prev_valid;
    int first_x;
    int first_y;
    int first_rgb;

    vga_rx_monitor #(.SYNC_POL(1'b0), .SUM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .i_r        (i_r),
        .i_g        (i_g),
        .i_b        (i_b),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .locked     (locked),
        .res_code   (res_code),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .x          (x),
        .y          (y),
        .h_total    (h_total),
        .v_total    (v_total),
        .frame_done (frame_done),
        .frame_sum  (frame_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt  = 0;
        done_cnt   = 0;
        consec_cnt = 0;
        first_seen = 1'b0;
        prev_valid = 1'b0;
        first_x    = -1;
        first_y    = -1;
        first_rgb  = -1;
    endtask

    // One clock with the given inputs, then observe the registered outputs.
    task automatic step(input logic pen, input logic hs, input logic vs);
        pix_en = pen;
        h_sync = hs;
        v_sync = vs;
        @(posedge clk);
        #1;
        if (pix_valid === 1'b1) begin
            valid_cnt++;
            if (prev_valid) consec_cnt++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_x    = int'(x);
                first_y    = int'(y);
                first_rgb  = int'(pix_rgb);
            end
        end
        prev_valid = (pix_valid === 1'b1);
        if (frame_done === 1'b1) done_cnt++;
    endtask

    // Lines l0..l1 of a frame; shortlen != 0 shrinks every line but the last to that length.
    task automatic send_lines(input int l0, input int l1, input int vtot, input int htot,
                              input int hsw, input int vsw, input int shortlen, input bit pen2);
        int   len;
        int   hw;
        logic hs;
        logic vs;
        for (int l = l0; l <= l1; l++) begin
            if (shortlen != 0 && l != vtot - 1) begin
                len = shortlen;
                hw  = 4;
            end else begin
                len = htot;
                hw  = hsw;
            end
            vs = (l < vsw) ? SA : SD;
            for (int p = 0; p < len; p++) begin
                hs = (p < hw) ? SA : SD;
                step(1'b1, hs, vs);
                if (pen2) step(1'b0, hs, vs);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        h_sync = SD;
        v_sync = SD;
        i_r    = 4'h0;
        i_g    = 4'h0;
        i_b    = 4'h0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_res", 32'(res_code), 32'd3);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_sum", 32'(frame_sum), 32'd0);
        check("rst_htot", 32'(h_total), 32'd0);
        rst = 1'b0;

        // 640x480: measurement frame, then lock at the next v_sync edge
        send_lines(0, 524, 525, 800, 96, 2, 16, 1'b0);
        check("meas_unlocked", 32'(locked), 32'd0);
        check("meas_res", 32'(res_code), 32'd3);
        i_b = 4'hF;
        clear_mon();
        send_lines(0, 0, 525, 800, 96, 2, 0, 1'b0);
        check("lock640_locked", 32'(locked), 32'd1);
        check("lock640_res", 32'(res_code), 32'd0);
        check("lock640_htot", 32'(h_total), 32'd800);
        check("lock640_vtot", 32'(v_total), 32'd525);
        send_lines(1, 524, 525, 800, 96, 2, 0, 1'b0);
        check("frame_no_done_yet", 32'(done_cnt), 32'd0);
        send_lines(0, 0, 525, 800, 96, 2, 0, 1'b0);
        check("frame_valid_cnt", 32'(valid_cnt), 32'd307200);
        check("frame_first_x", 32'(first_x), 32'd0);
        check("frame_first_y", 32'(first_y), 32'd0);
        check("frame_first_rgb", 32'(first_rgb), 32'h00F);
        check("frame_done_cnt", 32'(done_cnt), 32'd1);
        check("frame_done_low", 32'(frame_done), 32'd0);
        check("frame_sum", 32'(frame_sum), 32'(EXP_SUM));

        // Reset in the middle of a locked line with a valid pixel pending
        i_r = 4'h3; i_g = 4'hA; i_b = 4'h5;
        send_lines(1, 40, 525, 800, 96, 2, 0, 1'b0);
        for (int p = 0; p < 300; p++) step(1'b1, (p < 96) ? SA : SD, SD);
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        check("pre_rst_x", 32'(x), 32'd155);
        check("pre_rst_y", 32'(y), 32'd6);
        check("pre_rst_rgb", 32'(pix_rgb), 32'h3A5);
        rst = 1'b1;
        #1;
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_res", 32'(res_code), 32'd3);
        check("midrst_valid", 32'(pix_valid), 32'd0);
        check("midrst_sum", 32'(frame_sum), 32'd0);
        check("midrst_x", 32'(x), 32'd0);
        check("midrst_rgb", 32'(pix_rgb), 32'd0);
        step(1'b0, SD, SD);
        step(1'b0, SD, SD);
        rst = 1'b0;
        clear_mon();
        for (int p = 300; p < 800; p++) step(1'b1, SD, SD);
        send_lines(42, 524, 525, 800, 96, 2, 16, 1'b0);
        send_lines(0, 524, 525, 800, 96, 2, 16, 1'b0);
        check("relock_not_yet", 32'(locked), 32'd0);
        send_lines(0, 0, 525, 800, 96, 2, 0, 1'b0);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_res", 32'(res_code), 32'd0);
        check("relock_no_done", 32'(done_cnt), 32'd0);

        // h_sync stops: hcnt climbs from 799 and saturates on sample 1249
        for (int k = 0; k < 1200; k++) step(1'b1, SD, SD);
        check("stall_still_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 900; k++) step(1'b1, SD, SD);
        check("sat_locked", 32'(locked), 32'd0);
        check("sat_res", 32'(res_code), 32'd3);

        // Relock, then switch to 900-pixel lines
        send_lines(0, 524, 525, 800, 96, 2, 16, 1'b0);
        send_lines(0, 0, 525, 800, 96, 2, 0, 1'b0);
        check("relock2_locked", 32'(locked), 32'd1);
        send_lines(1, 2, 525, 900, 96, 2, 0, 1'b0);
        check("bad1_locked", 32'(locked), 32'd1);
        check("bad1_htot", 32'(h_total), 32'd900);
        send_lines(3, 3, 525, 900, 96, 2, 0, 1'b0);
        check("bad2_locked", 32'(locked), 32'd0);
        check("bad2_res", 32'(res_code), 32'd3);
        check("bad2_valid", 32'(pix_valid), 32'd0);

        // 800x600 with pix_en every other clock
        rst = 1'b1;
        step(1'b0, SD, SD);
        step(1'b0, SD, SD);
        rst = 1'b0;
        send_lines(0, 627, 628, 1056, 128, 4, 16, 1'b1);
        send_lines(0, 0, 628, 1056, 128, 4, 0, 1'b1);
        check("lock800_locked", 32'(locked), 32'd1);
        check("lock800_res", 32'(res_code), 32'd1);
        check("lock800_htot", 32'(h_total), 32'd1056);
        check("lock800_vtot", 32'(v_total), 32'd628);
        clear_mon();
        send_lines(1, 28, 628, 1056, 128, 4, 0, 1'b1);
        check("m800_valid_cnt", 32'(valid_cnt), 32'd1600);
        check("m800_consec", 32'(consec_cnt), 32'd0);
        check("m800_first_x", 32'(first_x), 32'd0);
        check("m800_first_y", 32'(first_y), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
